// File: rtl/multiplicador_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // The iteration counter has to hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplicador_seq_nbits_if.sv
// Operand/result handshake bundle for the sequential multiplier.
interface multiplicador_seq_nbits_if #(
    parameter int WIDTH = 4
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, p, busy
    );

endinterface

// File: rtl/somador_nbits.sv
// Parametrised ripple-carry adder used for the shift-add accumulate step.
module somador_nbits #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/multiplicador_seq_nbits.sv
// Radix-2 shift-add multiplier: one partial product per clock, signed or unsigned per operation.
module multiplicador_seq_nbits
    import multiplicador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic                      clk,
    input logic                      rst_n,
    multiplicador_seq_nbits_if.slave bus
);

    localparam int                  CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]       CNT_ONE  = {{(CW - 1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]       CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]    ONE_N    = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0]  ONE_2N   = {{(2 * WIDTH - 1){1'b0}}, 1'b1};

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc_hi;
    logic [WIDTH-1:0]     mplier;
    logic                 neg;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   p_q;
    logic                 out_valid_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg_in;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;
    logic [WIDTH:0]       partial;
    logic [WIDTH-1:0]     step_hi;
    logic [WIDTH-1:0]     step_lo;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_fixed;

    // The most-negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    always_comb begin
        a_mag  = bus.a;
        b_mag  = bus.b;
        neg_in = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        if (bus.signed_mode && bus.a[WIDTH-1]) begin
            a_mag = (~bus.a) + ONE_N;
        end
        if (bus.signed_mode && bus.b[WIDTH-1]) begin
            b_mag = (~bus.b) + ONE_N;
        end
    end

    somador_nbits #(
        .WIDTH (WIDTH)
    ) u_somador (
        .a    (acc_hi),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry rides along as the new MSB so the WIDTH+1-bit sum is never truncated.
    always_comb begin
        partial = {1'b0, acc_hi};
        if (mplier[0]) begin
            partial = {add_cout, add_sum};
        end
        step_hi = partial[WIDTH:1];
        step_lo = {partial[0], mplier[WIDTH-1:1]};
    end

    assign prod       = {acc_hi, mplier};
    assign prod_fixed = neg ? ((~prod) + ONE_2N) : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mcand       <= '0;
            acc_hi      <= '0;
            mplier      <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc_hi <= '0;
                        neg    <= neg_in;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    mplier <= step_lo;
                    cnt    <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    p_q         <= prod_fixed;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;

endmodule

// File: tb/tb_multiplicador_seq_nbits.sv
// Scoreboard bench for the sequential multiplier, exercising a 4-bit and an 8-bit instance.
module tb_multiplicador_seq_nbits;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multiplicador_seq_nbits_if #(.WIDTH(4)) bus4 ();
    multiplicador_seq_nbits_if #(.WIDTH(8)) bus8 ();

    multiplicador_seq_nbits #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    multiplicador_seq_nbits #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    logic        sel_wide;
    logic        drv_valid;
    logic        drv_sm;
    logic        drv_oready;
    logic [7:0]  drv_a;
    logic [7:0]  drv_b;
    logic        obs_in_ready;
    logic        obs_out_valid;
    logic        obs_busy;
    logic [15:0] obs_p;

    // One set of drivers steers whichever instance is selected; the other idles.
    assign bus4.in_valid    = drv_valid & ~sel_wide;
    assign bus4.a           = drv_a[3:0];
    assign bus4.b           = drv_b[3:0];
    assign bus4.signed_mode = drv_sm;
    assign bus4.out_ready   = sel_wide | drv_oready;
    assign bus8.in_valid    = drv_valid & sel_wide;
    assign bus8.a           = drv_a;
    assign bus8.b           = drv_b;
    assign bus8.signed_mode = drv_sm;
    assign bus8.out_ready   = ~sel_wide | drv_oready;

    assign obs_in_ready  = sel_wide ? bus8.in_ready  : bus4.in_ready;
    assign obs_out_valid = sel_wide ? bus8.out_valid : bus4.out_valid;
    assign obs_busy      = sel_wide ? bus8.busy      : bus4.busy;
    assign obs_p         = sel_wide ? bus8.p         : {8'h00, bus4.p};

    logic [15:0] sb[$];
    int checks = 0;
    int passes = 0;

    function automatic logic [15:0] model(input bit wide, input logic [7:0] a,
                                          input logic [7:0] b, input logic sm);
        int w;
        int ia;
        int ib;
        int pr;
        logic [15:0] r;
        w  = wide ? 8 : 4;
        ia = int'(a);
        ib = int'(b);
        if (sm && a[w-1]) ia = ia - (1 << w);
        if (sm && b[w-1]) ib = ib - (1 << w);
        pr = ia * ib;
        r  = pr[15:0];
        if (!wide) r[15:8] = 8'h00;
        return r;
    endfunction

    // Drives one operation; operands are scrambled after acceptance and an optional stray request is raised while stalled.
    task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          input logic sm, input int hold, input bit poke,
                          output logic [15:0] got, output int lat,
                          output bit rdy_ok, output bit stb_ok, output bit to);
        int n;
        got    = 16'hxxxx;
        lat    = 0;
        rdy_ok = 1'b1;
        stb_ok = 1'b1;
        to     = 1'b0;
        sel_wide   = wide;
        drv_a      = a;
        drv_b      = b;
        drv_sm     = sm;
        drv_oready = 1'b0;
        drv_valid  = 1'b1;
        n = 0;
        while (!obs_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!obs_in_ready) begin
            drv_valid = 1'b0;
            to = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_a     = ~a;
        drv_b     = ~b;
        drv_sm    = ~sm;
        forever begin
            if (obs_in_ready !== 1'b0) rdy_ok = 1'b0;
            if (obs_out_valid === 1'b1 || lat >= 100) break;
            @(negedge clk);
            lat++;
        end
        if (obs_out_valid !== 1'b1) begin
            to = 1'b1;
            drv_oready = 1'b1;
            return;
        end
        got = obs_p;
        if (hold > 0 && poke) begin
            drv_valid = 1'b1;
            drv_a     = 8'h01;
            drv_b     = 8'h01;
            drv_sm    = 1'b1;
        end
        repeat (hold) begin
            @(negedge clk);
            if (obs_p !== got || obs_out_valid !== 1'b1 || obs_in_ready !== 1'b0) stb_ok = 1'b0;
        end
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        sel_wide   = 1'b0;
        drv_valid  = 1'b0;
        drv_a      = 8'h00;
        drv_b      = 8'h00;
        drv_sm     = 1'b0;
        drv_oready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus4.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready4 got=%b exp=1", bus4.in_ready); else passes++;
        checks++; if (bus4.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid4 got=%b exp=0", bus4.out_valid); else passes++;
        checks++; if (bus4.p !== 8'h00) $display("[TB] FAIL reset_p4 got=%h exp=00", bus4.p); else passes++;
        checks++; if (bus4.busy !== 1'b0) $display("[TB] FAIL reset_busy4 got=%b exp=0", bus4.busy); else passes++;
        checks++; if (bus8.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready8 got=%b exp=1", bus8.in_ready); else passes++;
        checks++; if (bus8.p !== 16'h0000) $display("[TB] FAIL reset_p8 got=%h exp=0000", bus8.p); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0) $display("[TB] FAIL post_reset_idle4 in_ready=%b busy=%b exp 1/0", bus4.in_ready, bus4.busy); else passes++;
    endtask

    task automatic test_unsigned_max();
        logic [15:0] got;
        logic [15:0] exp;
        int lat;
        bit rdy_ok, stb_ok, to;
        sb.push_back(16'h00E1);
        run_op(1'b0, 8'd15, 8'd15, 1'b0, 0, 1'b0, got, lat, rdy_ok, stb_ok, to);
        exp = sb.pop_front();
        checks++; if (to) $display("[TB] FAIL umax_timeout got=1 exp=0"); else passes++;
        checks++; if (got !== exp) $display("[TB] FAIL umax_p got=%h exp=%h", got, exp); else passes++;
        checks++; if (lat != 5) $display("[TB] FAIL umax_latency got=%0d exp=5", lat); else passes++;
        checks++; if (!rdy_ok) $display("[TB] FAIL umax_in_ready_low got=high exp=low"); else passes++;
        checks++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) $display("[TB] FAIL umax_back_idle in_ready=%b out_valid=%b exp 1/0", obs_in_ready, obs_out_valid); else passes++;
    endtask

    task automatic test_signed();
        logic [7:0]  ta [6] = '{8'h0D, 8'h0D, 8'h08, 8'h08, 8'h00, 8'h0F};
        logic [7:0]  tb [6] = '{8'h05, 8'h05, 8'h08, 8'h01, 8'h05, 8'h00};
        logic        ts [6] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [15:0] te [6] = '{16'h00F1, 16'h0041, 16'h0040, 16'h00F8, 16'h0000, 16'h0000};
        logic [15:0] got;
        logic [15:0] exp;
        int lat;
        bit rdy_ok, stb_ok, to;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(te[i]);
            run_op(1'b0, ta[i], tb[i], ts[i], 0, 1'b0, got, lat, rdy_ok, stb_ok, to);
            exp = sb.pop_front();
            checks++; if (to || got !== exp) $display("[TB] FAIL signed_p[%0d] got=%h exp=%h timeout=%0d", i, got, exp, to); else passes++;
            checks++; if (lat != 5) $display("[TB] FAIL signed_latency[%0d] got=%0d exp=5", i, lat); else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got;
        logic [15:0] exp;
        int lat;
        bit rdy_ok, stb_ok, to;
        sb.push_back(16'h003F);
        run_op(1'b0, 8'd7, 8'd9, 1'b0, 3, 1'b1, got, lat, rdy_ok, stb_ok, to);
        exp = sb.pop_front();
        checks++; if (to || got !== exp) $display("[TB] FAIL bp_p got=%h exp=%h timeout=%0d", got, exp, to); else passes++;
        checks++; if (!stb_ok) $display("[TB] FAIL bp_hold got=unstable exp=stable"); else passes++;
        checks++; if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) $display("[TB] FAIL bp_release in_ready=%b out_valid=%b exp 1/0", obs_in_ready, obs_out_valid); else passes++;
        @(negedge clk);
        checks++; if (obs_busy !== 1'b0) $display("[TB] FAIL bp_poke_ignored busy got=%b exp=0", obs_busy); else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] got;
        logic [15:0] exp;
        int lat;
        bit rdy_ok, stb_ok, to;
        sel_wide   = 1'b0;
        drv_a      = 8'd7;
        drv_b      = 8'd9;
        drv_sm     = 1'b0;
        drv_oready = 1'b1;
        drv_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (obs_out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid got=%b exp=0", obs_out_valid); else passes++;
        checks++; if (obs_p !== 16'h0000) $display("[TB] FAIL midrst_p got=%h exp=0000", obs_p); else passes++;
        checks++; if (obs_in_ready !== 1'b1 || obs_busy !== 1'b0) $display("[TB] FAIL midrst_idle in_ready=%b busy=%b exp 1/0", obs_in_ready, obs_busy); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sb.push_back(16'h0009);
        run_op(1'b0, 8'd3, 8'd3, 1'b0, 0, 1'b0, got, lat, rdy_ok, stb_ok, to);
        exp = sb.pop_front();
        checks++; if (to || got !== exp) $display("[TB] FAIL midrst_after_p got=%h exp=%h timeout=%0d", got, exp, to); else passes++;
        checks++; if (lat != 5) $display("[TB] FAIL midrst_after_latency got=%0d exp=5", lat); else passes++;
    endtask

    task automatic test_wide();
        logic [7:0]  ta [3] = '{8'hFF, 8'h80, 8'hFF};
        logic [7:0]  tb [3] = '{8'hFF, 8'h80, 8'h7F};
        logic        ts [3] = '{1'b0,  1'b1,  1'b1};
        logic [15:0] te [3] = '{16'hFE01, 16'h4000, 16'hFF81};
        logic [15:0] got;
        logic [15:0] exp;
        int lat;
        bit rdy_ok, stb_ok, to;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(te[i]);
            run_op(1'b1, ta[i], tb[i], ts[i], 0, 1'b0, got, lat, rdy_ok, stb_ok, to);
            exp = sb.pop_front();
            checks++; if (to || got !== exp) $display("[TB] FAIL wide_p[%0d] got=%h exp=%h timeout=%0d", i, got, exp, to); else passes++;
            checks++; if (lat != 9) $display("[TB] FAIL wide_latency[%0d] got=%0d exp=9", i, lat); else passes++;
            checks++; if (!rdy_ok) $display("[TB] FAIL wide_in_ready_low[%0d] got=high exp=low", i); else passes++;
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] got;
        logic [15:0] exp;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rs;
        bit          wide;
        int          hold;
        int lat;
        bit rdy_ok, stb_ok, to;
        for (int i = 0; i < 1000; i++) begin
            wide = 1'($urandom_range(0, 1));
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 2));
            if (!wide) begin
                ra[7:4] = 4'h0;
                rb[7:4] = 4'h0;
            end
            sb.push_back(model(wide, ra, rb, rs));
            run_op(wide, ra, rb, rs, hold, 1'b0, got, lat, rdy_ok, stb_ok, to);
            exp = sb.pop_front();
            checks++;
            if (to || got !== exp || !stb_ok)
                $display("[TB] FAIL rand[%0d] w=%0d s=%0d a=%h b=%h got=%h exp=%h timeout=%0d stable=%0d", i, wide, rs, ra, rb, got, exp, to, stb_ok);
            else
                passes++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_reset_mid_op();
        test_wide();
        test_random_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
